// File: rtl/tbu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tbu_ctrl
//  Purpose  : Survivor-bank ring and traceback job sequencer (8-state Viterbi)
//  Revision : 1.0  initial release
// ============================================================================
module tbu_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic [3:0]    wr_en_bank,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [1:0]    trn_bank,
  output logic [1:0]    dec_bank,
  output logic          tbu_enable,
  output logic          tbu_selection,
  output logic          blk_done,
  output logic          overrun
);

  localparam logic [AW-1:0] C_ADDR_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAIN  = 2'd1,
    S_DECODE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_wbank;
  logic       r_primed;
  logic       r_pend;
  logic [1:0] r_pend_trn;

  logic       w_fill;
  logic       w_new_req;
  logic       w_req_avail;
  logic       w_take;
  logic       w_slot_load;
  logic       w_lost;
  logic [1:0] w_job_trn;
  logic       w_cur_read;
  logic       w_nxt_read;

  assign w_fill      = dec_valid && (wr_addr == C_ADDR_LAST);
  assign w_new_req   = w_fill && r_primed;
  assign w_req_avail = r_pend || w_new_req;
  assign w_take      = ((r_state == S_IDLE) || (r_state == S_GAP)) && w_req_avail;
  // A pending request has priority; a same-cycle new request then refills the slot.
  assign w_slot_load = w_new_req && (w_take ? r_pend : !r_pend);
  assign w_lost      = w_new_req && r_pend && !w_take;
  assign w_job_trn   = r_pend ? r_pend_trn : r_wbank;
  assign w_cur_read  = (r_state == S_TRAIN) || (r_state == S_DECODE);
  assign w_nxt_read  = (w_state_nxt == S_TRAIN) || (w_state_nxt == S_DECODE);

  assign wr_en_bank  = dec_valid ? (4'b0001 << r_wbank) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      r_wbank  <= 2'd0;
      r_primed <= 1'b0;
    end else if (dec_valid) begin
      wr_addr <= wr_addr + AW'(1);
      if (w_fill) begin
        r_wbank  <= r_wbank + 2'd1;
        r_primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_trn <= 2'd0;
      overrun    <= 1'b0;
      trn_bank   <= 2'd0;
      dec_bank   <= 2'd0;
    end else begin
      if (w_slot_load) begin
        r_pend     <= 1'b1;
        r_pend_trn <= r_wbank;
      end else if (w_take) begin
        r_pend <= 1'b0;
      end
      if (w_lost) begin
        overrun <= 1'b1;
      end
      if (w_take) begin
        trn_bank <= w_job_trn;
        dec_bank <= w_job_trn - 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req_avail) w_state_nxt = S_TRAIN;
      S_TRAIN:  if (rd_addr == '0) w_state_nxt = S_DECODE;
      S_DECODE: if (rd_addr == '0) w_state_nxt = S_GAP;
      S_GAP:    w_state_nxt = w_req_avail ? S_TRAIN : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // rd_addr doubles as the phase counter; unit controls lag one cycle for RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      tbu_enable    <= 1'b0;
      tbu_selection <= 1'b0;
      blk_done      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      rd_en         <= w_nxt_read;
      rd_addr       <= w_nxt_read ? (w_cur_read ? rd_addr - AW'(1) : C_ADDR_LAST) : '0;
      tbu_enable    <= w_cur_read;
      tbu_selection <= (r_state == S_DECODE);
      blk_done      <= (r_state == S_DECODE) && (rd_addr == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tbu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tbu_ctrl
//  Purpose  : Self-checking bench for tbu_ctrl (DEPTH=4) with a job scoreboard
//  Revision : 1.0  initial release
// ============================================================================
module tb_tbu_ctrl;

  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic [3:0]    wr_en_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    trn_bank;
  logic [1:0]    dec_bank;
  logic          tbu_enable;
  logic          tbu_selection;
  logic          blk_done;
  logic          overrun;

  tbu_ctrl #(.DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .wr_en_bank(wr_en_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .trn_bank(trn_bank), .dec_bank(dec_bank),
    .tbu_enable(tbu_enable), .tbu_selection(tbu_selection),
    .blk_done(blk_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int trn; int dec; int t0; } job_t;
  typedef struct { logic dv; logic [3:0] wen; int waddr; logic ren; } vec_t;

  job_t q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_wbank, m_waddr, m_primed, m_overrun, last_t0;
  logic [3:0] exp_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wbank = 0; m_waddr = 0; m_primed = 0; m_overrun = 0; last_t0 = -1000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dec_valid = 1'b0;
    #1;
    chk("rst_wr_en_bank", wr_en_bank, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_banks", {trn_bank, dec_bank}, 0);
    chk("rst_tbu", {tbu_enable, tbu_selection}, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle's input and check that cycle's outputs against the model.
  task automatic step_a(input logic dv);
    logic e_ren, e_en, e_sel, e_done;
    int   k;
    dec_valid = dv;
    exp_wen = dv ? (4'b0001 << m_wbank) : 4'b0000;
    @(negedge clk);
    e_ren = 0; e_en = 0; e_sel = 0; e_done = 0;
    chk("wr_en_bank", wr_en_bank, exp_wen);
    chk("wr_addr", wr_addr, m_waddr);
    chk("overrun", overrun, m_overrun);
    if (q.size() > 0 && cyc >= q[0].t0) begin
      k = cyc - q[0].t0;
      e_ren  = (k < 2*D);
      e_en   = (k >= 1);
      e_sel  = (k > D);
      e_done = (k == 2*D);
      chk("trn_bank", trn_bank, q[0].trn);
      chk("dec_bank", dec_bank, q[0].dec);
      if (e_ren) chk("rd_addr", rd_addr, D - 1 - (k % D));
      if (k == 2*D) void'(q.pop_front());
    end
    chk("rd_en", rd_en, e_ren);
    chk("tbu_enable", tbu_enable, e_en);
    chk("tbu_selection", tbu_selection, e_sel);
    chk("blk_done", blk_done, e_done);
  endtask

  // Advance the write/scheduling model, then the clock.
  task automatic step_b(input logic dv);
    bit pend;
    if (dv) begin
      if (m_waddr == D-1) begin
        if (m_primed != 0) begin
          pend = 0;
          foreach (q[i]) if (q[i].t0 > cyc + 1) pend = 1;
          if (pend) m_overrun = 1;
          else begin
            last_t0 = (cyc + 1 > last_t0 + 2*D + 1) ? cyc + 1 : last_t0 + 2*D + 1;
            q.push_back('{trn: m_wbank, dec: (m_wbank + 3) % 4, t0: last_t0});
          end
        end
        m_primed = 1;
        m_waddr = 0;
        m_wbank = (m_wbank + 1) % 4;
      end else begin
        m_waddr++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic dv);
    step_a(dv);
    step_b(dv);
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      step_a(vecs[i].dv);
      chk("tbl_wr_en_bank", wr_en_bank, vecs[i].wen);
      chk("tbl_wr_addr", wr_addr, vecs[i].waddr);
      chk("tbl_rd_en", rd_en, vecs[i].ren);
      step_b(vecs[i].dv);
    end
  endtask

  initial begin
    vecs[0] = '{dv: 1'b0, wen: 4'b0000, waddr: 0, ren: 1'b0};
    vecs[1] = '{dv: 1'b1, wen: 4'b0001, waddr: 0, ren: 1'b0};
    vecs[2] = '{dv: 1'b1, wen: 4'b0001, waddr: 1, ren: 1'b0};
    vecs[3] = '{dv: 1'b1, wen: 4'b0001, waddr: 2, ren: 1'b0};
    vecs[4] = '{dv: 1'b1, wen: 4'b0001, waddr: 3, ren: 1'b0};
    vecs[5] = '{dv: 1'b0, wen: 4'b0000, waddr: 0, ren: 1'b0};
    vecs[6] = '{dv: 1'b0, wen: 4'b0000, waddr: 0, ren: 1'b0};
    vecs[7] = '{dv: 1'b1, wen: 4'b0010, waddr: 0, ren: 1'b0};
    vecs[8] = '{dv: 1'b0, wen: 4'b0000, waddr: 1, ren: 1'b0};

    model_reset();
    do_reset();
    run_table();

    // 50% rate: fills bank 1 (idle start), then bank 2 during that job.
    for (int i = 0; i < 14; i++) step(i % 2 == 0);
    for (int i = 0; i < 30; i++) step(1'b0);

    // Continuous writes: third request lands on a full slot.
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);
    chk("overrun_sticky", overrun, 1);

    // Fresh start, then reset in the middle of a job.
    do_reset();
    run_table();
    for (int i = 0; i < 6; i++) step(i % 2 == 0);
    if (q.size() == 0) begin
      chk("midjob_scheduled", 0, 1);
    end else begin
      while (cyc < q[0].t0 + 5) step(1'b0);
      chk("midjob_active", tbu_enable, 1);
      do_reset();
    end
    run_table();
    for (int i = 0; i < 12; i++) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
